axi_lite_core_ctrl_regs: RTL and testbench
==========================================

Name: axi_lite_core_ctrl_regs

Overview:
- Parametrised AXI4-Lite slave register block that controls NUM_CORES accelerator cores.
- Each core gets CTRL, STATUS and NUM_ARGS argument registers, plus start/busy/done handshake signals.
- Has global interrupt-enable and interrupt-status registers and one level interrupt output.
- Sits between the AXI interconnect and the core array. It replaces a flat 4-register slave.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8: byte address width. Must satisfy 2^C_S_AXI_ADDR_WIDTH >= (NUM_CORES+1)*32.
- NUM_CORES, 4: number of core channels, 1..16.
- NUM_ARGS, 4: argument registers per core, 1..6.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
- core_start  out  NUM_CORES  one-cycle start pulse per core
- core_busy  out  NUM_CORES  core running
- core_done  in  NUM_CORES  one-cycle completion pulse from each core
- core_args  out  NUM_CORES*NUM_ARGS*32  flattened argument registers; core c, arg a at bits [(c*NUM_ARGS+a)*32 +: 32]
- irq  out  1  registered interrupt

Behaviour:
- Address map: word address = ADDR[ADDR_W-1:2]. Block index = word>>3, offset = word[2:0].
  - Blocks 0..NUM_CORES-1: offset 0 CTRL, offset 1 STATUS, offsets 2..2+NUM_ARGS-1 ARG.
  - Block NUM_CORES: offset 0 IRQ_EN (bits[NUM_CORES-1:0] RW), offset 1 IRQ_STAT (RO, done & irq_en).
  - Any other address is unmapped: writes have no effect and return SLVERR (2'b10); reads return 0 with SLVERR.
- Reset (asynchronous, any time, including mid-transaction):
  - All READY, VALID, core_start, core_busy and irq go to 0; BRESP, RRESP and RDATA go to 0.
  - All registers clear. Pending AW/W/AR captures are discarded.
  - One cycle after ARESET deasserts: AWREADY=WREADY=ARREADY=1.
- Write path:
  - AW and W are captured independently into holding registers.
  - AWREADY is high while no AW is held and BVALID=0; WREADY likewise for W.
  - The edge after both are held: commit the register effect, assert BVALID with BRESP, clear both holds.
  - BVALID holds until BREADY. AWREADY and WREADY return high the cycle after the B handshake. Only one write is outstanding.
- Read path:
  - ARREADY is high while RVALID=0. On the AR handshake edge, RDATA, RRESP and RVALID are registered (1-cycle latency).
  - R is held stable until RREADY; ARREADY is low meanwhile.
- Read and write paths are independent. A read of a register committed on the same edge returns the old value.
- ARG registers:
  - Byte-wise WSTRB merge.
  - A write while core_busy[c]=1 is ignored and answered SLVERR; otherwise OKAY.
- CTRL:
  - Write with WSTRB[0]=1 and WDATA[0]=1:
    - If core_busy[c]=0: core_start[c]=1 for exactly the commit cycle +1 (one cycle), core_busy[c] sets on the same edge, BRESP OKAY.
    - If core_busy[c]=1: no start, BRESP SLVERR.
  - CTRL reads as 0.
- STATUS:
  - bit0 = busy; bit1 = done (sticky).
  - core_done[c] pulse: busy clears, done sets. core_done while not busy is ignored.
  - Writing 1 to bit1 (WSTRB[0]) clears done. If a core_done pulse lands on the same edge, set wins.
  - A start commit clears done.
- IRQ: irq = |(done & irq_en), registered (one cycle after done or irq_en changes).

Test Plan:
- Reset then write ARG0 of core 2 (addr 0x48) = 0xDEADBEEF, WSTRB=0xF -> BRESP=0; read 0x48 returns 0xDEADBEEF; core_args bits [(2*4+0)*32 +: 32] = 0xDEADBEEF.
- W presented 3 cycles before AW, then BREADY low for 4 cycles -> BVALID stays high for 4 cycles; exactly one commit; AWREADY/WREADY low until the B handshake.
- IRQ_EN (0x80) = 0x1; write CTRL core 0 = 0x1 -> core_start[0] high for one cycle, STATUS=0x1; second start -> SLVERR; core_done[0] pulse -> STATUS=0x2, irq=1 next cycle; write STATUS 0x2 -> irq=0.
- Write ARG1 core 0 with WSTRB=0x2, data 0x0000AB00, over 0x11223344 -> read 0x1122AB44; write ARG while busy -> SLVERR, value unchanged.
- Read 0xA0 (unmapped) -> RDATA=0, RRESP=2'b10; write 0xA0 -> BRESP=2'b10.
- Assert ARESET while BVALID=1 and core_busy=1 -> all outputs 0 immediately, registers 0; after release a write completes normally.

Source files
------------

// File: rtl/axi_lite_core_ctrl_regs.sv
// AXI4-Lite register block controlling an array of accelerator cores.
// Each core has CTRL (start), STATUS (busy/done) and a set of argument
// registers. A global IRQ_EN / IRQ_STAT pair drives one level interrupt.
// Write and read channels are fully independent; one write outstanding.
module axi_lite_core_ctrl_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_CORES          = 4,
    parameter int NUM_ARGS           = 4
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_CORES-1:0]                 core_start,
    output logic [NUM_CORES-1:0]                 core_busy,
    input  logic [NUM_CORES-1:0]                 core_done,
    output logic [NUM_CORES*NUM_ARGS*32-1:0]     core_args,
    output logic                                 irq
);

    localparam int WORD_W   = C_S_AXI_ADDR_WIDTH - 2;
    localparam int BLK_W    = WORD_W - 3;
    localparam int NUM_REGS = NUM_CORES * NUM_ARGS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-lane merge of new write data over an existing register value.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        return {strb[3] ? new_v[31:24] : old_v[31:24],
                strb[2] ? new_v[23:16] : old_v[23:16],
                strb[1] ? new_v[15:8]  : old_v[15:8],
                strb[0] ? new_v[7:0]   : old_v[7:0]};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  aw_held_reg, w_held_reg;
    logic [WORD_W-1:0]     aw_word_reg;
    logic [31:0]           w_data_reg;
    logic [3:0]            w_strb_reg;
    logic                  awready_reg, wready_reg, bvalid_reg;
    logic [1:0]            bresp_reg;
    logic                  arready_reg, rvalid_reg;
    logic [1:0]            rresp_reg;
    logic [31:0]           rdata_reg;
    logic [NUM_REGS*32-1:0] args_reg, args_next;
    logic [NUM_CORES-1:0]  busy_reg, busy_next, done_reg, done_next;
    logic [NUM_CORES-1:0]  start_reg, irq_en_reg;
    logic                  irq_reg;

    // ------------------------------------------------------------------
    // Handshakes and channel next-state
    // ------------------------------------------------------------------
    logic aw_fire, w_fire, commit, b_fire, ar_fire, r_fire;
    logic aw_held_next, w_held_next, bvalid_next, rvalid_next;

    assign aw_fire = S_AXI_AWVALID && awready_reg;
    assign w_fire  = S_AXI_WVALID && wready_reg;
    assign commit  = aw_held_reg && w_held_reg;
    assign b_fire  = bvalid_reg && S_AXI_BREADY;
    assign ar_fire = S_AXI_ARVALID && arready_reg;
    assign r_fire  = rvalid_reg && S_AXI_RREADY;

    assign aw_held_next = commit ? 1'b0 : (aw_fire ? 1'b1 : aw_held_reg);
    assign w_held_next  = commit ? 1'b0 : (w_fire  ? 1'b1 : w_held_reg);
    assign bvalid_next  = commit ? 1'b1 : (b_fire  ? 1'b0 : bvalid_reg);
    assign rvalid_next  = ar_fire ? 1'b1 : (r_fire ? 1'b0 : rvalid_reg);

    // ------------------------------------------------------------------
    // Write decode (acts on the held address/data at commit)
    // ------------------------------------------------------------------
    logic [BLK_W-1:0]     wr_blk;
    logic [2:0]           wr_off;
    logic [NUM_CORES-1:0] wr_core_sel, wr_core_ok, start_fire, ctrl_err, clr_done, arg_err;
    logic                 wr_irq_blk, wr_mapped, wr_slverr, irq_en_we;
    logic [31:0]          irq_en_merged;

    assign wr_blk = aw_word_reg[WORD_W-1:3];
    assign wr_off = aw_word_reg[2:0];

    // ------------------------------------------------------------------
    // Read decode (acts on the live AR address)
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]    rd_word;
    logic [BLK_W-1:0]     rd_blk;
    logic [2:0]           rd_off;
    logic [NUM_CORES-1:0] rd_core_sel, rd_core_ok;
    logic                 rd_irq_blk, rd_mapped;
    logic [31:0]          rd_arg_or  [NUM_REGS+1];
    logic [31:0]          rd_stat_or [NUM_CORES+1];
    logic [31:0]          rd_irq_val, rd_data;

    assign rd_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_blk  = rd_word[WORD_W-1:3];
    assign rd_off  = rd_word[2:0];

    assign rd_arg_or[0]  = '0;
    assign rd_stat_or[0] = '0;

    genvar gi, ai;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            logic wr_ctrl_set, wr_arg_range;

            assign wr_core_sel[gi] = (wr_blk == BLK_W'(gi));
            assign wr_core_ok[gi]  = wr_core_sel[gi] && (int'(wr_off) < 2 + NUM_ARGS);
            assign wr_arg_range    = wr_core_sel[gi] && (int'(wr_off) >= 2) && (int'(wr_off) < 2 + NUM_ARGS);

            // CTRL: bit0 requests a start; refused while the core is running.
            assign wr_ctrl_set    = commit && wr_core_sel[gi] && (wr_off == 3'd0) && w_strb_reg[0] && w_data_reg[0];
            assign start_fire[gi] = wr_ctrl_set && !busy_reg[gi];
            assign ctrl_err[gi]   = wr_ctrl_set && busy_reg[gi];

            // STATUS: write-one-to-clear on the done bit.
            assign clr_done[gi] = commit && wr_core_sel[gi] && (wr_off == 3'd1) && w_strb_reg[0] && w_data_reg[1];
            assign arg_err[gi]  = commit && wr_arg_range && busy_reg[gi];

            // Start clears done; a done pulse only counts while busy and beats a clear.
            assign busy_next[gi] = start_fire[gi] ? 1'b1 :
                                   (core_done[gi] && busy_reg[gi]) ? 1'b0 : busy_reg[gi];
            assign done_next[gi] = start_fire[gi] ? 1'b0 :
                                   (core_done[gi] && busy_reg[gi]) ? 1'b1 :
                                   clr_done[gi] ? 1'b0 : done_reg[gi];

            assign rd_core_sel[gi] = (rd_blk == BLK_W'(gi));
            assign rd_core_ok[gi]  = rd_core_sel[gi] && (int'(rd_off) < 2 + NUM_ARGS);
            assign rd_stat_or[gi+1] = rd_stat_or[gi] |
                ((rd_core_sel[gi] && rd_off == 3'd1) ? {30'd0, done_reg[gi], busy_reg[gi]} : 32'd0);

            for (ai = 0; ai < NUM_ARGS; ai++) begin : g_arg
                localparam int         R   = gi * NUM_ARGS + ai;
                localparam logic [2:0] OFF = 3'(ai + 2);
                logic wr_hit;

                assign wr_hit = commit && wr_core_sel[gi] && (wr_off == OFF) && !busy_reg[gi];
                assign args_next[R*32 +: 32] = wr_hit ?
                    strb_merge(args_reg[R*32 +: 32], w_data_reg, w_strb_reg) : args_reg[R*32 +: 32];
                assign rd_arg_or[R+1] = rd_arg_or[R] |
                    ((rd_core_sel[gi] && rd_off == OFF) ? args_reg[R*32 +: 32] : 32'd0);
            end
        end
    endgenerate

    assign wr_irq_blk    = (wr_blk == BLK_W'(NUM_CORES));
    assign wr_mapped     = (|wr_core_ok) || (wr_irq_blk && wr_off <= 3'd1);
    assign wr_slverr     = !wr_mapped || (|ctrl_err) || (|arg_err);
    assign irq_en_we     = commit && wr_irq_blk && (wr_off == 3'd0);
    assign irq_en_merged = strb_merge({{(32-NUM_CORES){1'b0}}, irq_en_reg}, w_data_reg, w_strb_reg);

    assign rd_irq_blk = (rd_blk == BLK_W'(NUM_CORES));
    assign rd_mapped  = (|rd_core_ok) || (rd_irq_blk && rd_off <= 3'd1);
    assign rd_irq_val = !rd_irq_blk      ? 32'd0 :
                        (rd_off == 3'd0) ? {{(32-NUM_CORES){1'b0}}, irq_en_reg} :
                        (rd_off == 3'd1) ? {{(32-NUM_CORES){1'b0}}, done_reg & irq_en_reg} : 32'd0;
    // CTRL and unmapped addresses contribute nothing, so they read as zero.
    assign rd_data = rd_arg_or[NUM_REGS] | rd_stat_or[NUM_CORES] | rd_irq_val;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Write channel: independent AW/W capture, commit, B response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_word_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            bvalid_reg  <= bvalid_next;
            awready_reg <= !aw_held_next && !bvalid_next;
            wready_reg  <= !w_held_next && !bvalid_next;
            if (aw_fire) begin
                aw_word_reg <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_fire) begin
                w_data_reg <= S_AXI_WDATA;
                w_strb_reg <= S_AXI_WSTRB;
            end
            if (commit) begin
                bresp_reg <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read channel: one-cycle registered response held until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            rvalid_reg  <= rvalid_next;
            arready_reg <= !rvalid_next;
            if (ar_fire) begin
                rdata_reg <= rd_data;
                rresp_reg <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register file, core handshake state and interrupt.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            args_reg   <= '0;
            busy_reg   <= '0;
            done_reg   <= '0;
            start_reg  <= '0;
            irq_en_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            args_reg  <= args_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            start_reg <= start_fire;
            if (irq_en_we) begin
                irq_en_reg <= irq_en_merged[NUM_CORES-1:0];
            end
            irq_reg <= |(done_reg & irq_en_reg);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           irq_en_merged[31:NUM_CORES]};

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign core_start    = start_reg;
    assign core_busy     = busy_reg;
    assign core_args     = args_reg;
    assign irq           = irq_reg;

endmodule

// File: tb/tb_axi_lite_core_ctrl_regs.sv
// Self-checking bench for axi_lite_core_ctrl_regs: a table of single
// register transactions, then hand-written multi-cycle sequences.
module tb_axi_lite_core_ctrl_regs;

    localparam int NC = 4;
    localparam int NA = 4;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [7:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [7:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [NC-1:0] core_start, core_busy;
    logic [NC-1:0] core_done = '0;
    logic [NC*NA*32-1:0] core_args;
    logic        irq;

    axi_lite_core_ctrl_regs #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_CORES(NC), .NUM_ARGS(NA)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .core_args(core_args), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic        is_write;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [1:0]  exp_b_q[$];
    rexp_t       exp_r_q[$];
    logic [NC-1:0] start_at_b;
    vec_t        vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT, got none expected response", name);
    endtask

    // Waits (bounded) for BVALID; we are always #1 after a rising edge here.
    task automatic wait_bvalid(input string name, output bit ok);
        int cnt = 0;
        while (!S_AXI_BVALID && cnt < 20) begin
            @(posedge ACLK); #1;
            cnt++;
        end
        ok = S_AXI_BVALID;
        if (!ok) timeout_fail(name);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp, input string name);
        bit aw_done = 0, w_done = 0, ok;
        logic aw_hs, w_hs;
        logic [1:0] e;
        int cnt = 0;
        exp_b_q.push_back(exp_resp);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        while (!(aw_done && w_done) && cnt < 20) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            cnt++;
            if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        wait_bvalid(name, ok);
        e = exp_b_q.pop_front();
        start_at_b = '0;
        if (ok) begin
            start_at_b = core_start;
            check({name, " bresp"}, 64'(S_AXI_BRESP), 64'(e));
        end
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string name);
        bit done_hs = 0;
        logic ar_hs;
        rexp_t e;
        int cnt = 0;
        exp_r_q.push_back('{data: exp_data, resp: exp_resp});
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        while (!done_hs && cnt < 20) begin
            ar_hs = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            cnt++;
            if (ar_hs) done_hs = 1;
        end
        S_AXI_ARVALID = 1'b0;
        cnt = 0;
        while (!S_AXI_RVALID && cnt < 20) begin
            @(posedge ACLK); #1;
            cnt++;
        end
        e = exp_r_q.pop_front();
        if (!S_AXI_RVALID) begin
            timeout_fail(name);
        end else begin
            check({name, " rdata"}, 64'(S_AXI_RDATA), 64'(e.data));
            check({name, " rresp"}, 64'(S_AXI_RRESP), 64'(e.resp));
        end
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        bit ok;
        int bcount;
        logic [1:0] e;

        // Single-transaction vectors, applied from a clean reset state.
        vecs[0]  = '{1'b1, 8'h48, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
        vecs[1]  = '{1'b0, 8'h48, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1'b1, 8'h0C, 32'h11223344, 4'hF, 32'h0,        2'b00};
        vecs[3]  = '{1'b1, 8'h0C, 32'h0000AB00, 4'h2, 32'h0,        2'b00};
        vecs[4]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h1122AB44, 2'b00};
        vecs[5]  = '{1'b0, 8'hA0, 32'h0,        4'h0, 32'h0,        2'b10};
        vecs[6]  = '{1'b1, 8'hA0, 32'h12345678, 4'hF, 32'h0,        2'b10};
        vecs[7]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0,        2'b00};
        vecs[8]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h0,        2'b00};
        vecs[9]  = '{1'b1, 8'h80, 32'h00000001, 4'hF, 32'h0,        2'b00};
        vecs[10] = '{1'b0, 8'h80, 32'h0,        4'h0, 32'h1,        2'b00};
        vecs[11] = '{1'b0, 8'h1C, 32'h0,        4'h0, 32'h0,        2'b10};
        vecs[12] = '{1'b0, 8'h84, 32'h0,        4'h0, 32'h0,        2'b00};
        vecs[13] = '{1'b1, 8'h74, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00};
        vecs[14] = '{1'b0, 8'h74, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};

        // Reset state, then readiness one cycle after release.
        repeat (3) @(posedge ACLK);
        #1;
        check("rst awready", 64'(S_AXI_AWREADY), 64'd0);
        check("rst arready", 64'(S_AXI_ARREADY), 64'd0);
        check("rst bvalid",  64'(S_AXI_BVALID),  64'd0);
        check("rst busy",    64'(core_busy),     64'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("post-rst awready", 64'(S_AXI_AWREADY), 64'd1);
        check("post-rst wready",  64'(S_AXI_WREADY),  64'd1);
        check("post-rst arready", 64'(S_AXI_ARREADY), 64'd1);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_write)
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, $sformatf("vec%0d wr", i));
            else
                axi_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, $sformatf("vec%0d rd", i));
            if (i == 0) check("core_args c2a0", 64'(core_args[(2*NA+0)*32 +: 32]), 64'hDEADBEEF);
        end

        // W leads AW by three cycles; BREADY held low for four cycles.
        S_AXI_WDATA = 32'hA5A50F0F; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        check("early w wready", 64'(S_AXI_WREADY), 64'd0);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        check("early w awready", 64'(S_AXI_AWREADY), 64'd1);
        check("early w bvalid", 64'(S_AXI_BVALID), 64'd0);
        exp_b_q.push_back(2'b00);
        S_AXI_AWADDR = 8'h30; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        wait_bvalid("late aw", ok);
        bcount = 0;
        for (int k = 0; k < 4; k++) begin
            if (S_AXI_BVALID && !S_AXI_AWREADY && !S_AXI_WREADY) bcount++;
            @(posedge ACLK); #1;
        end
        check("bvalid held 4", 64'(bcount), 64'd4);
        e = exp_b_q.pop_front();
        check("late aw bresp", 64'(S_AXI_BRESP), 64'(e));
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        check("after b bvalid", 64'(S_AXI_BVALID), 64'd0);
        check("after b awready", 64'(S_AXI_AWREADY), 64'd1);
        check("after b wready", 64'(S_AXI_WREADY), 64'd1);
        check("core_args c1a2", 64'(core_args[(1*NA+2)*32 +: 32]), 64'hA5A50F0F);

        // Start/busy/done/irq sequence on core 0 (IRQ_EN=1 from the table).
        axi_write(8'h00, 32'h1, 4'h1, 2'b00, "start c0");
        check("start pulse", 64'(start_at_b), 64'h1);
        check("start one cycle", 64'(core_start), 64'h0);
        axi_read(8'h04, 32'h1, 2'b00, "status busy");
        axi_write(8'h00, 32'h1, 4'h1, 2'b10, "restart busy");
        check("no restart pulse", 64'(start_at_b), 64'h0);
        core_done = 4'b0001;
        @(posedge ACLK); #1;
        core_done = '0;
        check("irq lag", 64'(irq), 64'd0);
        @(posedge ACLK); #1;
        check("irq set", 64'(irq), 64'd1);
        axi_read(8'h04, 32'h2, 2'b00, "status done");
        axi_read(8'h84, 32'h1, 2'b00, "irq_stat");
        axi_write(8'h04, 32'h2, 4'h1, 2'b00, "clear done");
        check("irq cleared", 64'(irq), 64'd0);
        axi_read(8'h04, 32'h0, 2'b00, "status clear");

        // ARG writes refused while the core is busy; stray done ignored.
        axi_write(8'h28, 32'h55AA55AA, 4'hF, 2'b00, "c1 arg0");
        axi_write(8'h20, 32'h1, 4'h1, 2'b00, "start c1");
        axi_write(8'h28, 32'h99999999, 4'hF, 2'b10, "arg busy");
        axi_read(8'h28, 32'h55AA55AA, 2'b00, "arg unchanged");
        core_done = 4'b0100;
        @(posedge ACLK); #1;
        core_done = '0;
        axi_read(8'h44, 32'h0, 2'b00, "idle done ignored");

        // Reset in the middle of a pending B response with a core busy.
        check("pre-rst busy", 64'(core_busy), 64'h2);
        S_AXI_AWADDR = 8'h48; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        wait_bvalid("mid rst write", ok);
        ARESET = 1'b1;
        #1;
        check("mid rst bvalid", 64'(S_AXI_BVALID), 64'd0);
        check("mid rst busy", 64'(core_busy), 64'd0);
        check("mid rst awready", 64'(S_AXI_AWREADY), 64'd0);
        check("mid rst args", 64'(|core_args), 64'd0);
        check("mid rst irq", 64'(irq), 64'd0);
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("rerst awready", 64'(S_AXI_AWREADY), 64'd1);
        axi_write(8'h48, 32'h12345678, 4'hF, 2'b00, "post rst wr");
        axi_read(8'h48, 32'h12345678, 2'b00, "post rst rd");
        axi_read(8'h80, 32'h0, 2'b00, "irq_en cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
